hazard_stall_ctrl: RTL and testbench

Central pipeline sequencing controller for the 5-stage RV32 core. It generates the write-enable, flush and redirect controls for the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. It resolves load-use hazards, taken branches and jumps, instruction- and data-memory wait states, and serializing instructions that need an empty pipeline. It also keeps stall, flush and timeout statistics.

---
 rtl/hazard_stall_ctrl_if.sv | 59 +++++
 rtl/hazard_stall_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline sequencing bundle between the 5-stage RV32 datapath and the hazard/stall controller.
//
// Signals:
//   Hazard inputs    : rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, serialize_ID, rd_EX,
//                      MemRead_EX, branch_taken_EX, imem_ready, dmem_req_MEM, dmem_ready
//   Register controls: PC_WriteEN, IF_ID_WriteEN, ID_EX_WriteEN, EX_MEM_WriteEN,
//                      IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush, redirect
//   Status           : state, stall_cycles, flush_count, mem_timeout
//
// Modports:
//   master - the datapath side: drives the hazard inputs, consumes the controls.
//   slave  - the controller side.
//
// Handshake: imem_ready and dmem_ready are per-cycle completion strobes. A data access
// is outstanding in any cycle with dmem_req_MEM=1 and dmem_ready=0; it completes in the
// first cycle where both are 1. Fetch data is usable only in a cycle with imem_ready=1.
// Neither side is ever back-pressured by the other; the controller only observes them.
interface hazard_stall_ctrl_if;
    logic [4:0]  rs1_ID;
    logic [4:0]  rs2_ID;
    logic        use_rs1_ID;
    logic        use_rs2_ID;
    logic        serialize_ID;
    logic [4:0]  rd_EX;
    logic        MemRead_EX;
    logic        branch_taken_EX;
    logic        imem_ready;
    logic        dmem_req_MEM;
    logic        dmem_ready;

    logic        PC_WriteEN;
    logic        IF_ID_WriteEN;
    logic        ID_EX_WriteEN;
    logic        EX_MEM_WriteEN;
    logic        IF_ID_Flush;
    logic        ID_EX_Flush;
    logic        MEM_WB_Flush;
    logic        redirect;
    logic [1:0]  state;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    logic        mem_timeout;

    modport master (
        output rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, serialize_ID, rd_EX,
               MemRead_EX, branch_taken_EX, imem_ready, dmem_req_MEM, dmem_ready,
        input  PC_WriteEN, IF_ID_WriteEN, ID_EX_WriteEN, EX_MEM_WriteEN,
               IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush, redirect,
               state, stall_cycles, flush_count, mem_timeout
    );

    modport slave (
        input  rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, serialize_ID, rd_EX,
               MemRead_EX, branch_taken_EX, imem_ready, dmem_req_MEM, dmem_ready,
        output PC_WriteEN, IF_ID_WriteEN, ID_EX_WriteEN, EX_MEM_WriteEN,
               IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush, redirect,
               state, stall_cycles, flush_count, mem_timeout
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central pipeline sequencing controller for the 5-stage RV32 core.
// Produces write-enable / flush / redirect controls for PC, IF_ID, ID_EX, EX_MEM and
// MEM_WB, resolving (in priority order) data-memory freezes, taken branches/jumps,
// load-use hazards, serializing instructions and instruction-fetch waits.
//
// Ports:
//   clk - sole clock, rising edge
//   rst - synchronous active-high reset
//   bus - hazard_stall_ctrl_if.slave (hazard inputs, register controls, state,
//         stall_cycles / flush_count performance counters, sticky mem_timeout)
//
// Parameters:
//   DRAIN_DEPTH - cycles a serializing instruction is held in ID
//   MEM_TIMEOUT - consecutive freeze cycles before mem_timeout sets
module hazard_stall_ctrl #(
    parameter int DRAIN_DEPTH = 3,
    parameter int MEM_TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst,
    hazard_stall_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam int DW = (DRAIN_DEPTH > 1) ? $clog2(DRAIN_DEPTH) : 1;
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    state_t        state_q, state_d, eff_state;
    logic [DW-1:0] drain_q, drain_d;
    logic          ret_drain_q, ret_drain_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          timeout_q;
    logic [31:0]   stall_q, flush_q;

    logic pc_we, if_id_we, id_ex_we, ex_mem_we;
    logic if_id_fl, id_ex_fl, mem_wb_fl, redir;
    logic count_flush;
    logic freeze, load_use;

    assign freeze   = bus.dmem_req_MEM & ~bus.dmem_ready;
    assign load_use = bus.MemRead_EX && (bus.rd_EX != 5'd0) &&
                      ((bus.use_rs1_ID && (bus.rs1_ID == bus.rd_EX)) ||
                       (bus.use_rs2_ID && (bus.rs2_ID == bus.rd_EX)));

    // MEM_WAIT is a wrapper around whichever state the freeze interrupted; once the
    // freeze lifts, decisions are made as if still in that underlying state.
    always_comb begin
        eff_state = state_q;
        if (state_q == MEM_WAIT) begin
            eff_state = ret_drain_q ? DRAIN : RUN;
        end
    end

    always_comb begin
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        id_ex_we    = 1'b1;
        ex_mem_we   = 1'b1;
        if_id_fl    = 1'b0;
        id_ex_fl    = 1'b0;
        mem_wb_fl   = 1'b0;
        redir       = 1'b0;
        count_flush = 1'b0;
        state_d     = RUN;
        drain_d     = drain_q;
        ret_drain_d = ret_drain_q;

        if (rst) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            if_id_fl  = 1'b1;
            id_ex_fl  = 1'b1;
            mem_wb_fl = 1'b1;
        end else if (freeze) begin
            // A taken branch in EX stays put while frozen and is acted on afterwards.
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_we    = 1'b0;
            ex_mem_we   = 1'b0;
            mem_wb_fl   = 1'b1;
            state_d     = MEM_WAIT;
            ret_drain_d = (eff_state == DRAIN);
        end else if (bus.branch_taken_EX) begin
            // PC loads the target even when fetch is not ready; IF_ID is flushed anyway.
            if_id_fl    = 1'b1;
            id_ex_fl    = 1'b1;
            redir       = 1'b1;
            count_flush = 1'b1;
            drain_d     = '0;
            state_d     = RUN;
        end else if (load_use) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            id_ex_fl = 1'b1;
            state_d  = eff_state;
        end else if (eff_state == RUN && bus.serialize_ID) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            id_ex_fl = 1'b1;
            drain_d  = DW'(DRAIN_DEPTH - 1);
            state_d  = DRAIN;
        end else if (eff_state == DRAIN && drain_q != '0) begin
            pc_we    = 1'b0;
            if_id_we = 1'b0;
            id_ex_fl = 1'b1;
            drain_d  = drain_q - 1'b1;
            state_d  = DRAIN;
        end else begin
            // Normal flow, including the issue cycle at the end of a drain.
            if (!bus.imem_ready) begin
                pc_we    = 1'b0;
                if_id_fl = 1'b1;
            end
            state_d = RUN;
        end
    end

    always_comb begin
        wait_d = '0;
        if (freeze) begin
            wait_d = (wait_q == WW'(MEM_TIMEOUT)) ? wait_q : wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            drain_q     <= '0;
            ret_drain_q <= 1'b0;
            wait_q      <= '0;
            timeout_q   <= 1'b0;
            stall_q     <= '0;
            flush_q     <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            ret_drain_q <= ret_drain_d;
            wait_q      <= wait_d;
            if (wait_d == WW'(MEM_TIMEOUT)) begin
                timeout_q <= 1'b1;
            end
            stall_q <= stall_q + {31'd0, ~pc_we};
            flush_q <= flush_q + {31'd0, count_flush};
        end
    end

    assign bus.PC_WriteEN     = pc_we;
    assign bus.IF_ID_WriteEN  = if_id_we;
    assign bus.ID_EX_WriteEN  = id_ex_we;
    assign bus.EX_MEM_WriteEN = ex_mem_we;
    assign bus.IF_ID_Flush    = if_id_fl;
    assign bus.ID_EX_Flush    = id_ex_fl;
    assign bus.MEM_WB_Flush   = mem_wb_fl;
    assign bus.redirect       = redir;
    assign bus.state          = state_q;
    assign bus.stall_cycles   = stall_q;
    assign bus.flush_count    = flush_q;
    assign bus.mem_timeout    = timeout_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl.
// Control outputs are packed as {PC_WE, IF_ID_WE, ID_EX_WE, EX_MEM_WE,
// IF_ID_Flush, ID_EX_Flush, MEM_WB_Flush, redirect}.
module tb_hazard_stall_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;

    localparam logic [7:0] C_DEF    = 8'b1111_0000;
    localparam logic [7:0] C_RST    = 8'b0000_1110;
    localparam logic [7:0] C_FREEZE = 8'b0000_0010;
    localparam logic [7:0] C_REDIR  = 8'b1111_1101;
    localparam logic [7:0] C_HOLD   = 8'b0011_0100;
    localparam logic [7:0] C_FETCH  = 8'b0111_1000;
    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_MWAIT  = 2'd2;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(.DRAIN_DEPTH(3), .MEM_TIMEOUT(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        bus.rs1_ID          = 5'd0;
        bus.rs2_ID          = 5'd0;
        bus.use_rs1_ID      = 1'b0;
        bus.use_rs2_ID      = 1'b0;
        bus.serialize_ID    = 1'b0;
        bus.rd_EX           = 5'd0;
        bus.MemRead_EX      = 1'b0;
        bus.branch_taken_EX = 1'b0;
        bus.imem_ready      = 1'b1;
        bus.dmem_req_MEM    = 1'b0;
        bus.dmem_ready      = 1'b1;
    endtask

    // Inputs are driven 1 time unit after the edge; checks happen 2 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                            input logic [4:0] r2, input logic u2);
        bus.MemRead_EX = 1'b1;
        bus.rd_EX      = rd;
        bus.rs1_ID     = r1;
        bus.use_rs1_ID = u1;
        bus.rs2_ID     = r2;
        bus.use_rs2_ID = u2;
    endtask

    function automatic logic [7:0] ctl();
        return {bus.PC_WriteEN, bus.IF_ID_WriteEN, bus.ID_EX_WriteEN, bus.EX_MEM_WriteEN,
                bus.IF_ID_Flush, bus.ID_EX_Flush, bus.MEM_WB_Flush, bus.redirect};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (ctl() !== C_RST) begin
            failures++; $display("FAIL rst_ctl got=%b exp=%b", ctl(), C_RST);
        end
        next_cycle();
        rst = 1'b0;
        #2;
        checks++;
        if (bus.state !== S_RUN) begin
            failures++; $display("FAIL rst_state got=%0d exp=%0d", bus.state, S_RUN);
        end
        checks++;
        if (bus.stall_cycles !== 32'd0 || bus.flush_count !== 32'd0 || bus.mem_timeout !== 1'b0) begin
            failures++;
            $display("FAIL rst_regs got stall=%0d flush=%0d tmo=%b exp 0/0/0",
                     bus.stall_cycles, bus.flush_count, bus.mem_timeout);
        end
        checks++;
        if (ctl() !== C_DEF) begin
            failures++; $display("FAIL idle_ctl got=%b exp=%b", ctl(), C_DEF);
        end
        exp_stall = 32'd0;
        exp_flush = 32'd0;
    endtask

    task automatic test_load_use();
        // lw x5 in EX, add x6,x5,x1 in ID
        next_cycle(); set_load(5'd5, 5'd5, 1'b1, 5'd1, 1'b1); #2;
        checks++;
        if (ctl() !== C_HOLD) begin
            failures++; $display("FAIL lu_rs1_ctl got=%b exp=%b", ctl(), C_HOLD);
        end
        exp_stall++;
        next_cycle(); set_idle(); #2;
        checks++;
        if (ctl() !== C_DEF) begin
            failures++; $display("FAIL lu_after_ctl got=%b exp=%b", ctl(), C_DEF);
        end
        checks++;
        if (bus.stall_cycles !== exp_stall) begin
            failures++; $display("FAIL lu_stall got=%0d exp=%0d", bus.stall_cycles, exp_stall);
        end
        // rd_EX = x0 never creates a hazard
        next_cycle(); set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1); #2;
        checks++;
        if (ctl() !== C_DEF) begin
            failures++; $display("FAIL lu_x0_ctl got=%b exp=%b", ctl(), C_DEF);
        end
        // match through rs2 only
        next_cycle(); set_load(5'd7, 5'd3, 1'b1, 5'd7, 1'b1); #2;
        checks++;
        if (ctl() !== C_HOLD) begin
            failures++; $display("FAIL lu_rs2_ctl got=%b exp=%b", ctl(), C_HOLD);
        end
        exp_stall++;
        // matching rs1 that is not actually read
        next_cycle(); set_load(5'd7, 5'd7, 1'b0, 5'd2, 1'b1); #2;
        checks++;
        if (ctl() !== C_DEF) begin
            failures++; $display("FAIL lu_unused_ctl got=%b exp=%b", ctl(), C_DEF);
        end
        // register match but EX is not a load
        next_cycle(); set_load(5'd9, 5'd9, 1'b1, 5'd0, 1'b0); bus.MemRead_EX = 1'b0; #2;
        checks++;
        if (ctl() !== C_DEF) begin
            failures++; $display("FAIL lu_noload_ctl got=%b exp=%b", ctl(), C_DEF);
        end
        next_cycle(); set_idle(); #2;
        checks++;
        if (bus.stall_cycles !== exp_stall) begin
            failures++; $display("FAIL lu_stall2 got=%0d exp=%0d", bus.stall_cycles, exp_stall);
        end
    endtask

    task automatic test_branch();
        next_cycle(); bus.branch_taken_EX = 1'b1; #2;
        checks++;
        if (ctl() !== C_REDIR) begin
            failures++; $display("FAIL br_ctl got=%b exp=%b", ctl(), C_REDIR);
        end
        exp_flush++;
        next_cycle(); set_idle(); #2;
        checks++;
        if (bus.flush_count !== exp_flush) begin
            failures++; $display("FAIL br_flush got=%0d exp=%0d", bus.flush_count, exp_flush);
        end
        // redirect together with a load-use: redirect only
        next_cycle(); set_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0); bus.branch_taken_EX = 1'b1; #2;
        checks++;
        if (ctl() !== C_REDIR) begin
            failures++; $display("FAIL br_lu_ctl got=%b exp=%b", ctl(), C_REDIR);
        end
        exp_flush++;
        // redirect with fetch not ready: PC still loads target
        next_cycle(); set_idle(); bus.branch_taken_EX = 1'b1; bus.imem_ready = 1'b0; #2;
        checks++;
        if (ctl() !== C_REDIR) begin
            failures++; $display("FAIL br_imem_ctl got=%b exp=%b", ctl(), C_REDIR);
        end
        exp_flush++;
        next_cycle(); set_idle(); #2;
        checks++;
        if (bus.flush_count !== exp_flush || bus.stall_cycles !== exp_stall) begin
            failures++;
            $display("FAIL br_counts got flush=%0d stall=%0d exp flush=%0d stall=%0d",
                     bus.flush_count, bus.stall_cycles, exp_flush, exp_stall);
        end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus.dmem_req_MEM = 1'b1; bus.dmem_ready = 1'b0; bus.branch_taken_EX = 1'b1;
            #2;
            checks++;
            if (ctl() !== C_FREEZE) begin
                failures++; $display("FAIL mw_ctl[%0d] got=%b exp=%b", i, ctl(), C_FREEZE);
            end
            checks++;
            if (bus.state !== ((i == 0) ? S_RUN : S_MWAIT)) begin
                failures++; $display("FAIL mw_state[%0d] got=%0d", i, bus.state);
            end
            exp_stall++;
        end
        next_cycle(); bus.dmem_ready = 1'b1; #2;
        checks++;
        if (ctl() !== C_REDIR || bus.state !== S_MWAIT) begin
            failures++;
            $display("FAIL mw_release got ctl=%b state=%0d exp ctl=%b state=%0d",
                     ctl(), bus.state, C_REDIR, S_MWAIT);
        end
        exp_flush++;
        next_cycle(); set_idle(); #2;
        checks++;
        if (bus.state !== S_RUN || bus.flush_count !== exp_flush || bus.stall_cycles !== exp_stall) begin
            failures++;
            $display("FAIL mw_after got state=%0d flush=%0d stall=%0d exp state=0 flush=%0d stall=%0d",
                     bus.state, bus.flush_count, bus.stall_cycles, exp_flush, exp_stall);
        end
    endtask

    task automatic test_serialize();
        // plain drain: held 3 cycles, issues in the 4th
        next_cycle(); bus.serialize_ID = 1'b1; #2;
        checks++;
        if (ctl() !== C_HOLD || bus.state !== S_RUN) begin
            failures++; $display("FAIL ser_c1 got ctl=%b state=%0d", ctl(), bus.state);
        end
        exp_stall++;
        for (int i = 0; i < 2; i++) begin
            next_cycle(); #2;
            checks++;
            if (ctl() !== C_HOLD || bus.state !== S_DRAIN) begin
                failures++; $display("FAIL ser_hold[%0d] got ctl=%b state=%0d", i, ctl(), bus.state);
            end
            exp_stall++;
        end
        next_cycle(); #2;
        checks++;
        if (ctl() !== C_DEF || bus.state !== S_DRAIN) begin
            failures++; $display("FAIL ser_issue got ctl=%b state=%0d", ctl(), bus.state);
        end
        next_cycle(); set_idle(); #2;
        checks++;
        if (bus.state !== S_RUN || bus.stall_cycles !== exp_stall) begin
            failures++;
            $display("FAIL ser_done got state=%0d stall=%0d exp state=0 stall=%0d",
                     bus.state, bus.stall_cycles, exp_stall);
        end

        // branch in cycle 2 aborts the drain
        next_cycle(); bus.serialize_ID = 1'b1; #2;
        exp_stall++;
        next_cycle(); bus.branch_taken_EX = 1'b1; #2;
        checks++;
        if (ctl() !== C_REDIR || bus.state !== S_DRAIN) begin
            failures++; $display("FAIL ser_abort got ctl=%b state=%0d", ctl(), bus.state);
        end
        exp_flush++;
        next_cycle(); set_idle(); #2;
        checks++;
        if (bus.state !== S_RUN || ctl() !== C_DEF || bus.flush_count !== exp_flush) begin
            failures++;
            $display("FAIL ser_abort_after got state=%0d ctl=%b flush=%0d exp flush=%0d",
                     bus.state, ctl(), bus.flush_count, exp_flush);
        end

        // freeze in the middle of a drain returns to the drain with its count intact
        next_cycle(); bus.serialize_ID = 1'b1; #2;
        exp_stall++;
        next_cycle(); bus.dmem_req_MEM = 1'b1; bus.dmem_ready = 1'b0; #2;
        checks++;
        if (ctl() !== C_FREEZE || bus.state !== S_DRAIN) begin
            failures++; $display("FAIL ser_frz1 got ctl=%b state=%0d", ctl(), bus.state);
        end
        exp_stall++;
        next_cycle(); #2;
        exp_stall++;
        next_cycle(); bus.dmem_ready = 1'b1; #2;
        checks++;
        if (ctl() !== C_HOLD || bus.state !== S_MWAIT) begin
            failures++; $display("FAIL ser_frz_release got ctl=%b state=%0d", ctl(), bus.state);
        end
        exp_stall++;
        // fetch not ready during a drain hold: IF_ID holds, no IF_ID flush
        next_cycle(); bus.dmem_req_MEM = 1'b0; bus.imem_ready = 1'b0; #2;
        checks++;
        if (ctl() !== C_HOLD || bus.state !== S_DRAIN) begin
            failures++; $display("FAIL ser_frz_drain got ctl=%b state=%0d", ctl(), bus.state);
        end
        exp_stall++;
        next_cycle(); bus.imem_ready = 1'b1; #2;
        checks++;
        if (ctl() !== C_DEF || bus.state !== S_DRAIN) begin
            failures++; $display("FAIL ser_frz_issue got ctl=%b state=%0d", ctl(), bus.state);
        end
        next_cycle(); set_idle(); #2;
        checks++;
        if (bus.state !== S_RUN || bus.stall_cycles !== exp_stall) begin
            failures++;
            $display("FAIL ser_frz_done got state=%0d stall=%0d exp stall=%0d",
                     bus.state, bus.stall_cycles, exp_stall);
        end
    endtask

    task automatic test_fetch_wait();
        for (int i = 0; i < 2; i++) begin
            next_cycle(); bus.imem_ready = 1'b0; #2;
            checks++;
            if (ctl() !== C_FETCH) begin
                failures++; $display("FAIL fw_ctl[%0d] got=%b exp=%b", i, ctl(), C_FETCH);
            end
            exp_stall++;
        end
        next_cycle(); set_idle(); #2;
        checks++;
        if (ctl() !== C_DEF || bus.stall_cycles !== exp_stall) begin
            failures++;
            $display("FAIL fw_after got ctl=%b stall=%0d exp ctl=%b stall=%0d",
                     ctl(), bus.stall_cycles, C_DEF, exp_stall);
        end
    endtask

    task automatic test_timeout();
        for (int k = 1; k <= 300; k++) begin
            next_cycle(); bus.dmem_req_MEM = 1'b1; bus.dmem_ready = 1'b0; #2;
            exp_stall++;
            if (k == 1 || k == 256 || k == 257 || k == 300) begin
                checks++;
                if (bus.mem_timeout !== (k >= 257)) begin
                    failures++;
                    $display("FAIL tmo_cycle%0d got=%b exp=%b", k, bus.mem_timeout, (k >= 257));
                end
            end
        end
        next_cycle(); bus.dmem_ready = 1'b1; #2;
        checks++;
        if (ctl() !== C_DEF || bus.state !== S_MWAIT || bus.mem_timeout !== 1'b1) begin
            failures++;
            $display("FAIL tmo_release got ctl=%b state=%0d tmo=%b", ctl(), bus.state, bus.mem_timeout);
        end
        next_cycle(); set_idle(); #2;
        checks++;
        if (bus.mem_timeout !== 1'b1 || bus.stall_cycles !== exp_stall) begin
            failures++;
            $display("FAIL tmo_sticky got tmo=%b stall=%0d exp tmo=1 stall=%0d",
                     bus.mem_timeout, bus.stall_cycles, exp_stall);
        end
        // reset while in MEM_WAIT
        next_cycle(); bus.dmem_req_MEM = 1'b1; bus.dmem_ready = 1'b0;
        next_cycle(); #2;
        checks++;
        if (bus.state !== S_MWAIT) begin
            failures++; $display("FAIL tmo_mwait got=%0d exp=%0d", bus.state, S_MWAIT);
        end
        next_cycle(); rst = 1'b1; #2;
        checks++;
        if (ctl() !== C_RST) begin
            failures++; $display("FAIL tmo_rst_ctl got=%b exp=%b", ctl(), C_RST);
        end
        next_cycle(); rst = 1'b0; set_idle(); #2;
        exp_stall = 32'd0;
        exp_flush = 32'd0;
        checks++;
        if (bus.state !== S_RUN || bus.mem_timeout !== 1'b0 ||
            bus.stall_cycles !== exp_stall || bus.flush_count !== exp_flush) begin
            failures++;
            $display("FAIL tmo_after_rst got state=%0d tmo=%b stall=%0d flush=%0d exp 0/0/0/0",
                     bus.state, bus.mem_timeout, bus.stall_cycles, bus.flush_count);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks    = 0;
        failures  = 0;
        exp_stall = 32'd0;
        exp_flush = 32'd0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_serialize();
        test_fetch_wait();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
